datapath_p: RTL

Parametrised second-generation CPU datapath: register file, ALU, PC/LR/IR/ALUOUT registers and the shared tristate `SysBus`, generalised in data width and register count. It adds three things to the existing datapath:
- a hardware link-register stack for nested calls and interrupts;
- an iterative multi-cycle multiplier with a start/busy/done handshake;
- registered ALU flags.

It sits between the control FSM and the memory interface and is driven cycle-by-cycle by the control unit.

---
 rtl/datapath_p.sv | 262 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/datapath_p.sv
// datapath_p: parametrised CPU datapath with register file, ALU, PC/IR/AluOut
// registers, link-register stack, iterative shift-add multiplier and a shared
// tristate system bus.
module datapath_p #(
  parameter int          WIDTH      = 16,
  parameter int          NREGS      = 8,
  parameter int          LR_DEPTH   = 4,
  parameter logic [15:0] INT_VECTOR = 16'h0010,
  localparam int         AW         = $clog2(NREGS)
) (
  input  logic             Clock,
  input  logic             nReset,
  inout  wire  [WIDTH-1:0] SysBus,
  input  logic [WIDTH-1:0] DataIn,
  input  logic             MemEn,
  input  logic             PcEn,
  input  logic             LrEn,
  input  logic             AluEn,
  output logic [WIDTH-1:0] Ir,
  input  logic             IrWe,
  input  logic [AW-1:0]    Rs1,
  input  logic [AW-1:0]    Rs2,
  input  logic [AW-1:0]    Rw,
  input  logic             RegWe,
  input  logic             WdSel,
  input  logic             Op1Sel,
  input  logic [1:0]       Op2Sel,
  input  logic [WIDTH-1:0] Imm,
  input  logic [2:0]       AluOp,
  input  logic             CarryIn,
  input  logic             AluWe,
  output logic [3:0]       Flags,
  input  logic [2:0]       PcSel,
  input  logic             PcWe,
  input  logic             LrSel,
  input  logic             LrPush,
  input  logic             LrPop,
  input  logic             LrErrClr,
  output logic             LrEmpty,
  output logic             LrFull,
  output logic             LrOvf,
  output logic             LrUnf,
  input  logic             MulStart,
  output logic             MulBusy,
  output logic             MulDone
);

  localparam int CW = $clog2(LR_DEPTH + 1);
  localparam int SW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] INT_VEC_W = WIDTH'(INT_VECTOR);

  typedef enum logic [1:0] {M_IDLE, M_RUN, M_DONE} mstate_t;

  logic [WIDTH-1:0]   regs_q [NREGS];
  logic [WIDTH-1:0]   pc_q, pc_d, ir_q, aluout_q;
  logic [3:0]         flags_q;
  logic [WIDTH-1:0]   lr_q [LR_DEPTH];
  logic [WIDTH-1:0]   lr_d [LR_DEPTH];
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               ovf_q, ovf_d, unf_q, unf_d;
  mstate_t            mstate_q;
  logic [2*WIDTH-1:0] mcand_q, prod_q, prod_nx;
  logic [WIDTH-1:0]   mplier_q;
  logic [SW-1:0]      step_q;
  logic               busy_q, done_q, mul_fin;

  logic [WIDTH-1:0]   rd1, rd2, op1, op2, wd, pc_inc, lr_in, lr_top, alu_res;
  logic [WIDTH:0]     alu_sum;
  logic               alu_c, alu_v;

  assign rd1    = regs_q[Rs1];
  assign rd2    = regs_q[Rs2];
  assign op1    = Op1Sel ? pc_q : rd1;
  assign op2    = (Op2Sel == 2'd0) ? rd2 : (Op2Sel == 2'd1) ? Imm : '0;
  assign wd     = WdSel ? SysBus : alu_res;
  assign pc_inc = pc_q + WIDTH'(1);
  assign lr_in  = LrSel ? SysBus : pc_inc;
  // Entries above the count are always zero, so the top reads 0 when empty.
  assign lr_top = lr_q[0];

  // Priority mux keeps a single driver; the controller guarantees one enable.
  assign SysBus = MemEn ? DataIn :
                  PcEn  ? pc_q :
                  LrEn  ? lr_top :
                  AluEn ? aluout_q : {WIDTH{1'bz}};

  assign Ir      = ir_q;
  assign Flags   = flags_q;
  assign LrEmpty = (cnt_q == '0);
  assign LrFull  = (cnt_q == CW'(LR_DEPTH));
  assign LrOvf   = ovf_q;
  assign LrUnf   = unf_q;
  assign MulBusy = busy_q;
  assign MulDone = done_q;

  // Register file: synchronous write, reads see the pre-edge contents.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (RegWe) begin
      regs_q[Rw] <= wd;
    end
  end

  // Combinational ALU; carry and overflow derived from a one-bit-wider sum.
  always_comb begin
    alu_res = '0;
    alu_sum = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (AluOp)
      3'd0: begin
        alu_sum = {1'b0, op1} + {1'b0, op2} + {{WIDTH{1'b0}}, CarryIn};
        alu_res = alu_sum[WIDTH-1:0];
        alu_c   = alu_sum[WIDTH];
        alu_v   = (op1[WIDTH-1] == op2[WIDTH-1]) && (alu_res[WIDTH-1] != op1[WIDTH-1]);
      end
      3'd1: begin
        alu_sum = {1'b0, op1} + {1'b0, ~op2} + {{WIDTH{1'b0}}, CarryIn};
        alu_res = alu_sum[WIDTH-1:0];
        alu_c   = alu_sum[WIDTH];
        alu_v   = (op1[WIDTH-1] != op2[WIDTH-1]) && (alu_res[WIDTH-1] != op1[WIDTH-1]);
      end
      3'd2: alu_res = op1 & op2;
      3'd3: alu_res = op1 | op2;
      3'd4: alu_res = op1 ^ op2;
      3'd5: begin
        alu_res = {op1[WIDTH-2:0], 1'b0};
        alu_c   = op1[WIDTH-1];
      end
      3'd6: begin
        alu_res = {1'b0, op1[WIDTH-1:1]};
        alu_c   = op1[0];
      end
      default: alu_res = '0;
    endcase
  end

  // Next PC selection; codes 5-7 hold the current value.
  always_comb begin
    pc_d = pc_q;
    case (PcSel)
      3'd0:    pc_d = pc_inc;
      3'd1:    pc_d = lr_top;
      3'd2:    pc_d = alu_res;
      3'd3:    pc_d = SysBus;
      3'd4:    pc_d = INT_VEC_W;
      default: pc_d = pc_q;
    endcase
  end

  // PC and IR registers.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      pc_q <= '0;
      ir_q <= '0;
    end else begin
      if (PcWe) pc_q <= pc_d;
      if (IrWe) ir_q <= SysBus;
    end
  end

  // Link stack next state: shift-register stack, top at index 0.
  always_comb begin
    lr_d  = lr_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q & ~LrErrClr;
    unf_d = unf_q & ~LrErrClr;
    if (LrPush && (!LrPop || cnt_q == '0)) begin
      for (int i = LR_DEPTH - 1; i > 0; i--) lr_d[i] = lr_q[i-1];
      lr_d[0] = lr_in;
      if (cnt_q == CW'(LR_DEPTH)) ovf_d = 1'b1;
      else                        cnt_d = cnt_q + CW'(1);
    end else if (LrPush && LrPop) begin
      lr_d[0] = lr_in;
    end else if (LrPop) begin
      if (cnt_q == '0) begin
        unf_d = 1'b1;
      end else begin
        for (int i = 0; i < LR_DEPTH - 1; i++) lr_d[i] = lr_q[i+1];
        lr_d[LR_DEPTH-1] = '0;
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  // Link stack state registers.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      for (int i = 0; i < LR_DEPTH; i++) lr_q[i] <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      lr_q  <= lr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign prod_nx = prod_q + (mplier_q[0] ? mcand_q : '0);
  assign mul_fin = (mstate_q == M_RUN) && (step_q == SW'(WIDTH - 1));

  // Multiplier FSM: one shift-add step per RUN cycle, one-cycle DONE pulse.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      mstate_q <= M_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      step_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (mstate_q)
        M_IDLE: begin
          done_q <= 1'b0;
          if (MulStart) begin
            mcand_q  <= {{WIDTH{1'b0}}, op1};
            mplier_q <= op2;
            prod_q   <= '0;
            step_q   <= '0;
            busy_q   <= 1'b1;
            mstate_q <= M_RUN;
          end
        end
        M_RUN: begin
          prod_q   <= prod_nx;
          mcand_q  <= {mcand_q[2*WIDTH-2:0], 1'b0};
          mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
          step_q   <= step_q + SW'(1);
          if (mul_fin) begin
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            mstate_q <= M_DONE;
          end
        end
        default: begin
          done_q   <= 1'b0;
          mstate_q <= M_IDLE;
        end
      endcase
    end
  end

  // AluOut/Flags: the multiplier result wins; ALU writes only while idle.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      aluout_q <= '0;
      flags_q  <= '0;
    end else if (mul_fin) begin
      aluout_q <= prod_nx[WIDTH-1:0];
      flags_q  <= {prod_nx[WIDTH-1:0] == '0, prod_nx[WIDTH-1],
                   prod_nx[2*WIDTH-1:WIDTH] != '0, 1'b0};
    end else if (AluWe && AluOp != 3'd7 && mstate_q == M_IDLE) begin
      aluout_q <= alu_res;
      flags_q  <= {alu_res == '0, alu_res[WIDTH-1], alu_c, alu_v};
    end
  end

endmodule
